am_tdm_modulator: RTL
=====================

AM_TDM_MODULATOR -- requirements
Module: am_tdm_modulator

Interface
REQ-001 SHALL have parameter W, default 12, meaning sample, carrier and config width, all signed Q1.(W-1).
REQ-002 SHALL have parameter NCH, default 4, meaning number of time-multiplexed channels (2..16).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, meaning pipeline enable; low freezes all pipeline and counter state.
REQ-006 SHALL have port in_valid, input, 1, meaning base/carr/in_first carry a sample this cycle.
REQ-007 SHALL have port in_first, input, 1, meaning the current sample belongs to channel 0 (resync).
REQ-008 SHALL have port base, input, W, meaning baseband sample m[n].
REQ-009 SHALL have port carr, input, W, meaning carrier sample aligned with base.
REQ-010 SHALL have port cfg_we, input, 1, meaning write strobe for the per-channel config.
REQ-011 SHALL have port cfg_ch, input, clog2(NCH), meaning target channel of the write.
REQ-012 SHALL have port cfg_shift, input, W, meaning carrier shift a0 in [0,1).
REQ-013 SHALL have port cfg_index, input, W, meaning modulation index M in [0,1).
REQ-014 SHALL have port cfg_mode, input, 2, meaning 0=OFF, 1=REG (regular AM), 2=DSB, 3=reserved (treated as OFF).
REQ-015 SHALL have port modout, output, W, meaning modulated sample, Q1.(W-1).
REQ-016 SHALL have port out_valid, output, 1, meaning modout is valid this cycle.
REQ-017 SHALL have port out_ch, output, clog2(NCH), meaning channel of modout.
REQ-018 SHALL have port sat_flag, output, 1, meaning sticky overflow indicator.

Function
REQ-019 SHALL accept a sample when in_valid && en; the channel tag is 0 if in_first, otherwise the internal counter value.
REQ-020 SHALL advance the channel counter on each accepted sample to tag+1, wrapping from NCH-1 to 0.
REQ-021 SHALL use a 3-stage pipeline; modout/out_valid/out_ch SHALL appear 3 enabled cycles after acceptance.
REQ-022 Stage 1 SHALL compute m_attn = (base*index) >>> (W-1) (arithmetic shift, floor), giving W bits.
REQ-023 Stage 2 SHALL compute m_shift (W+1 bits) = m_attn + shift for REG, m_attn for DSB, and 0 for OFF/reserved.
REQ-024 Stage 3 SHALL compute p = (m_shift*carr) >>> (W-1) at full width; modout is p reduced to W bits per REQ-033/034.
REQ-025 SHALL delay carr internally so it is multiplied with the m_shift derived from the same accepted sample.
REQ-026 SHALL latch config (shift/index/mode) for the tagged channel at stage 1; all three are used for that sample.
REQ-027 On cfg_we the addressed channel SHALL update on the next edge; a sample accepted in the same cycle SHALL use the old values.
REQ-028 cfg_we SHALL take effect regardless of en; cfg_ch >= NCH SHALL be ignored.
REQ-029 With en low, out_valid SHALL hold its value, and no new sample SHALL be accepted.
REQ-030 in_valid low SHALL insert a bubble (out_valid 0 three enabled cycles later); the counter is unchanged.

Reset
REQ-031 On rst: counter=0; all pipeline registers, modout, out_ch = 0; out_valid=0; sat_flag=0; all channels shift=0, index=0, mode=OFF.
REQ-032 rst mid-stream SHALL discard in-flight samples; the first sample accepted after reset is channel 0.

Configuration
REQ-033 With macro AM_TDM_MOD_SAT_EN defined: p > 2^(W-1)-1 SHALL give 2^(W-1)-1, p < -2^(W-1) SHALL give -2^(W-1), and either case SHALL set sat_flag (cleared only by rst).
REQ-034 With AM_TDM_MOD_SAT_EN undefined: modout SHALL be the low W bits of p (two's-complement wrap), and sat_flag SHALL be tied 0.

Verification (W=12, NCH=4)
REQ-035 Ch0 REG shift=1024 index=1024; base=2047, carr=2047, in_first=1 -> 3 cycles later modout=2046, out_ch=0, out_valid=1.
REQ-036 Ch1 REG shift=2047 index=2047; base=2047, carr=2047 -> SAT_EN: modout=2047, sat_flag=1; without: modout=-5, sat_flag=0. Same with carr=-2048 -> SAT_EN: -2048; without: 3.
REQ-037 Ch2 DSB shift=1000 index=2047; base=-1024, carr=2047 -> modout=-1024 (shift ignored); ch3 OFF -> modout=0 with out_valid=1.
REQ-038 Five back-to-back samples, in_first on the 1st only -> out_ch sequence 0,1,2,3,0; in_first on the 3rd sample -> tags 0,1,0,1,2.
REQ-039 cfg_we to ch0 (index 1024->0) in the same cycle ch0 is accepted -> that sample uses 1024; the next ch0 sample in REG with shift=1024, carr=2047 gives modout=1023.
REQ-040 en low 2 cycles mid-stream -> out_valid/modout frozen, latency extended by 2; rst asserted with 3 samples in flight -> out_valid=0 next cycle, and the next sample is tagged ch0.

Source files
------------

// File: rtl/am_tdm_modulator.sv
// Time-multiplexed AM modulator: per-channel index/shift/mode config, 3-stage multiply pipeline.
// Define AM_TDM_MOD_SAT_EN for output saturation with a sticky sat_flag; otherwise output wraps.
module am_tdm_modulator #(
  parameter int unsigned W   = 12,
  parameter int unsigned NCH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic signed [W-1:0]           base,
  input  logic signed [W-1:0]           carr,
  input  logic                          cfg_we,
  input  logic        [$clog2(NCH)-1:0] cfg_ch,
  input  logic signed [W-1:0]           cfg_shift,
  input  logic signed [W-1:0]           cfg_index,
  input  logic        [1:0]             cfg_mode,
  output logic signed [W-1:0]           modout,
  output logic                          out_valid,
  output logic        [$clog2(NCH)-1:0] out_ch,
  output logic                          sat_flag
);

  localparam int unsigned CW = $clog2(NCH);
  localparam logic [1:0] ModeReg = 2'd1;
  localparam logic [1:0] ModeDsb = 2'd2;

  logic signed [W-1:0] r_cfg_shift [NCH];
  logic signed [W-1:0] r_cfg_index [NCH];
  logic        [1:0]   r_cfg_mode  [NCH];
  logic [CW-1:0]       r_cnt;

  logic                r1_valid;
  logic [CW-1:0]       r1_ch;
  logic signed [W-1:0] r1_mattn;
  logic signed [W-1:0] r1_shift;
  logic [1:0]          r1_mode;
  logic signed [W-1:0] r1_carr;

  logic                r2_valid;
  logic [CW-1:0]       r2_ch;
  logic signed [W:0]   r2_mshift;
  logic signed [W-1:0] r2_carr;

  logic [CW-1:0]         w_tag;
  logic signed [2*W-1:0] w_prod1;
  logic signed [W-1:0]   w_mattn;
  logic signed [W:0]     w_mshift;
  logic signed [2*W:0]   w_prod3;
  logic signed [W-1:0]   w_res;
  logic                  w_unused;

  assign w_tag   = in_first ? '0 : r_cnt;
  assign w_prod1 = (2*W)'(base) * (2*W)'(r_cfg_index[w_tag]);
  assign w_mattn = w_prod1[2*W-2:W-1];

  always_comb begin
    w_mshift = '0;
    case (r1_mode)
      ModeReg: w_mshift = (W+1)'(r1_mattn) + (W+1)'(r1_shift);
      ModeDsb: w_mshift = (W+1)'(r1_mattn);
      default: w_mshift = '0;
    endcase
  end

  assign w_prod3 = (2*W+1)'(r2_mshift) * (2*W+1)'(r2_carr);

`ifdef AM_TDM_MOD_SAT_EN
  // p = w_prod3[2W:W-1]; it fits W bits only when its top three bits agree
  logic [2:0] w_top;
  logic       w_ovf;
  logic       r_sat;

  assign w_top    = w_prod3[2*W:2*W-2];
  assign w_ovf    = (w_top != 3'b000) && (w_top != 3'b111);
  assign w_res    = !w_ovf ? w_prod3[2*W-2:W-1] :
                    w_prod3[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign w_unused = ^{w_prod1[2*W-1], w_prod1[W-2:0], w_prod3[W-2:0]};
  assign sat_flag = r_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (en && r2_valid && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_res    = w_prod3[2*W-2:W-1];
  assign w_unused = ^{w_prod1[2*W-1], w_prod1[W-2:0], w_prod3[2*W:2*W-1], w_prod3[W-2:0]};
  assign sat_flag = 1'b0;
`endif

  // Config writes ignore en; a same-cycle sample has already read the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        r_cfg_shift[i] <= '0;
        r_cfg_index[i] <= '0;
        r_cfg_mode[i]  <= 2'd0;
      end
    end else if (cfg_we && (32'(cfg_ch) < NCH)) begin
      r_cfg_shift[cfg_ch] <= cfg_shift;
      r_cfg_index[cfg_ch] <= cfg_index;
      r_cfg_mode[cfg_ch]  <= cfg_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r1_valid  <= 1'b0;
      r1_ch     <= '0;
      r1_mattn  <= '0;
      r1_shift  <= '0;
      r1_mode   <= 2'd0;
      r1_carr   <= '0;
      r2_valid  <= 1'b0;
      r2_ch     <= '0;
      r2_mshift <= '0;
      r2_carr   <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      modout    <= '0;
    end else if (en) begin
      if (in_valid) begin
        r_cnt <= (w_tag == CW'(NCH - 1)) ? '0 : w_tag + CW'(1);
      end
      r1_valid  <= in_valid;
      r1_ch     <= w_tag;
      r1_mattn  <= w_mattn;
      r1_shift  <= r_cfg_shift[w_tag];
      r1_mode   <= r_cfg_mode[w_tag];
      r1_carr   <= carr;
      r2_valid  <= r1_valid;
      r2_ch     <= r1_ch;
      r2_mshift <= w_mshift;
      r2_carr   <= r1_carr;
      out_valid <= r2_valid;
      out_ch    <= r2_ch;
      modout    <= w_res;
    end
  end

endmodule
